dct_block_sequencer: RTL and testbench
======================================

// Module: dct_block_sequencer
// PURPOSE
//  Streams an 8x8 block of Q16.16 words through the dct_2d_8x8 datapath, which has fixed latency.
//  - Collects 64 input words serially over a valid/ready handshake.
//  - Holds the packed matrix stable on dct_in_matrix for DCT_LATENCY cycles, then captures dct_out_matrix.
//  - Replays the 64 coefficients serially over a second valid/ready handshake.
//  - Sits between the YCbCr stage and quantisation. The DCT instance is external; its ports connect here.
// PARAMETERS
//  DATA_WIDTH   32  bits per word (Q16.16)
//  DATA_DEPTH   8   matrix side; block holds DATA_DEPTH*DATA_DEPTH words
//  DCT_LATENCY  8   cycles from stable dct_in_matrix to valid dct_out_matrix (>=1)
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      asynchronous reset, active-high
//  in_valid        in   1      input word valid
//  in_ready        out  1      sequencer can accept a word
//  in_data         in   W      input word, row-major order (index = row*8+col)
//  in_last         in   1      sender marks word 63
//  out_valid       out  1      output coefficient valid
//  out_ready       in   1      downstream accepts the coefficient
//  out_data        out  W      output coefficient, row-major order
//  out_last        out  1      high with coefficient 63
//  dct_in_matrix   out  W*64   to DCT; word i at [i*W +: W]
//  dct_out_matrix  in   W*64   from DCT, same packing
//  busy            out  1      high in WAIT or DRAIN
//  frame_err       out  1      sticky: in_last position mismatch
//  blk_count       out  16     (only with DCT_SEQ_STATS_EN) blocks fully drained
// BEHAVIOUR
//  Reset values: all outputs 0, in_ready=1, state FILL, idx=0. Reset mid-block discards the partial block.
//  FSM, 3 states:
//   - FILL: in_ready=1. On each in_valid&in_ready, store in_data at idx and increment idx. On idx==63: idx<=0, go WAIT.
//   - WAIT: in_ready=0. A cycle counter runs 0..DCT_LATENCY-1, then dct_out_matrix is captured into out_buf and the FSM goes DRAIN.
//   - DRAIN: out_valid=1, out_data=out_buf[idx]. Advance idx on out_valid&out_ready. On the handshake of idx 63: idx<=0, go FILL.
//  dct_in_matrix is registered and changes only in FILL. It is stable throughout WAIT.
//  Timing: first out_valid occurs DCT_LATENCY+1 cycles after the 64th input handshake. in_ready rises the cycle after the out_last handshake. Input and output never overlap (no ping-pong).
//  out_valid/out_data/out_last hold while out_ready=0. Backpressure has no cycle limit.
//  in_last check:
//   - in_last=1 with idx!=63 -> frame_err<=1.
//   - in_last=0 at idx==63 -> frame_err<=1.
//   - In both cases the word is still accepted and counting is unchanged. frame_err clears only on reset.
//  in_valid during WAIT/DRAIN is ignored (in_ready=0). The sender must hold the word.
// CONFIGURATION
//  DCT_SEQ_STATS_EN defined:
//   - blk_count port exists. It increments on each out_last handshake and wraps 0xFFFF->0. Reset value 0.
//  DCT_SEQ_STATS_EN undefined:
//   - port and counter absent. All other behaviour identical.
// STRUCTURE
//  Package dct_seq_pkg:
//   - state enum {ST_FILL, ST_WAIT, ST_DRAIN}
//   - BLOCK_WORDS=64, IDX_W=6
//   - function lat_cnt_w(DCT_LATENCY)
//  Sub-module dct_word_buffer (64xW register array):
//   - single write port; indexed read; parallel load/unload
//   - instanced twice: input packer, output capture
// TESTING
//  1. Ramp block in_data=i<<16, i=0..63, out_ready=1, DCT model = identity with latency 8.
//     -> out_data=i<<16 in order; out_last on 63; first out_valid 9 cycles after the last input.
//  2. in_valid toggling 1/0 each cycle.
//     -> exactly 64 handshakes; WAIT entered only after the 64th; dct_in_matrix unchanged during WAIT.
//  3. out_ready low for 20 cycles at idx 10.
//     -> out_data holds word 10; no skip or duplicate; in_ready stays 0 until the out_last handshake.
//  4. in_last asserted on word 40.
//     -> frame_err=1 next cycle and stays set; block still completes with 64 outputs.
//  5. reset pulse at idx 30 in DRAIN.
//     -> out_valid=0, in_ready=1, frame_err=0 immediately; next full block processed correctly.
//  6. With DCT_SEQ_STATS_EN: 3 back-to-back blocks.
//     -> blk_count=3. Real dct_2d_8x8 with random data: |diff| <= 0x8000 vs golden.

Source files
------------

// File: rtl/dct_seq_pkg.sv
// Shared types and constants for the 8x8 DCT block sequencer.
package dct_seq_pkg;

  typedef enum logic [1:0] {ST_FILL, ST_WAIT, ST_DRAIN} state_t;

  localparam int BLOCK_WORDS = 64;
  localparam int IDX_W       = 6;

  // Width of the WAIT cycle counter, which runs 0..lat-1.
  function automatic int lat_cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/dct_block_sequencer_buffer.sv
// Purpose: N-word register array with one serial write port, an indexed read and a parallel load/unload.
// Latency: writes and loads land on the next clock edge; rd_dat and flat are combinational from the array.
// Backpressure: none; the owner decides when to write or load.
module dct_word_buffer
  import dct_seq_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = BLOCK_WORDS,
  parameter int AW = IDX_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_idx,
  input  logic [W-1:0]   wr_dat,
  input  logic           load_en,
  input  logic [W*N-1:0] load_dat,
  input  logic [AW-1:0]  rd_idx,
  output logic [W-1:0]   rd_dat,
  output logic [W*N-1:0] flat
);

  logic [W*N-1:0] mem;

  // A parallel load wins over a serial write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (load_en) begin
      mem <= load_dat;
    end else if (wr_en) begin
      mem[wr_idx*W +: W] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_idx*W +: W];
  assign flat   = mem;

endmodule

// File: rtl/dct_block_sequencer.sv
// Purpose: gathers an 8x8 block, holds it on the external DCT for DCT_LATENCY cycles, replays the coefficients.
// Latency: first out_valid DCT_LATENCY+1 cycles after the 64th input handshake; in_ready returns after out_last.
// Backpressure: in_ready low outside FILL; out_valid/out_data hold indefinitely while out_ready is low.
// Optional macro DCT_SEQ_STATS_EN adds the blk_count port.
module dct_block_sequencer
  import dct_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_DEPTH  = 8,
  parameter int DCT_LATENCY = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATA_WIDTH-1:0]                     in_data,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic                                      out_last,
  output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] dct_in_matrix,
  input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] dct_out_matrix,
  output logic                                      busy,
`ifdef DCT_SEQ_STATS_EN
  output logic [15:0]                               blk_count,
`endif
  output logic                                      frame_err
);

  localparam int WORDS = DATA_DEPTH * DATA_DEPTH;
  localparam int AW    = $clog2(WORDS);
  localparam int CW    = lat_cnt_w(DCT_LATENCY);
  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(DCT_LATENCY - 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [CW-1:0]   lat_cnt, lat_cnt_nxt;
  logic            cap_en;
  logic            in_hs, out_hs;
  logic [DATA_WIDTH-1:0]       pack_rd_dat;
  logic [DATA_WIDTH*WORDS-1:0] cap_flat;
  logic            unused_bits;

  assign in_ready  = (state == ST_FILL);
  assign out_valid = (state == ST_DRAIN);
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign busy      = (state == ST_WAIT) || (state == ST_DRAIN);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_FILL;
      idx     <= '0;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    lat_cnt_nxt = lat_cnt;
    cap_en      = 1'b0;
    case (state)
      ST_FILL: begin
        lat_cnt_nxt = '0;
        if (in_hs) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = ST_WAIT;
          end else begin
            idx_nxt = idx + AW'(1);
          end
        end
      end
      ST_WAIT: begin
        // Capture on the last counted cycle so out_buf is ready the cycle DRAIN starts.
        if (lat_cnt == LAT_LAST) begin
          cap_en      = 1'b1;
          lat_cnt_nxt = '0;
          state_nxt   = ST_DRAIN;
        end else begin
          lat_cnt_nxt = lat_cnt + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (out_hs) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = ST_FILL;
          end else begin
            idx_nxt = idx + AW'(1);
          end
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // Word accepted regardless; a misplaced or missing in_last only raises the sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else if (in_hs && (in_last != (idx == LAST_IDX))) begin
      frame_err <= 1'b1;
    end
  end

  dct_word_buffer #(.W(DATA_WIDTH), .N(WORDS), .AW(AW)) u_in_pack (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (in_hs),
    .wr_idx   (idx),
    .wr_dat   (in_data),
    .load_en  (1'b0),
    .load_dat ('0),
    .rd_idx   (idx),
    .rd_dat   (pack_rd_dat),
    .flat     (dct_in_matrix)
  );

  dct_word_buffer #(.W(DATA_WIDTH), .N(WORDS), .AW(AW)) u_out_cap (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (1'b0),
    .wr_idx   ('0),
    .wr_dat   ('0),
    .load_en  (cap_en),
    .load_dat (dct_out_matrix),
    .rd_idx   (idx),
    .rd_dat   (out_data),
    .flat     (cap_flat)
  );

  assign unused_bits = ^{pack_rd_dat, cap_flat};

`ifdef DCT_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_count <= '0;
    end else if (out_hs && out_last) begin
      blk_count <= blk_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Randomised bench for dct_block_sequencer with a block-level reference model and a delayed-identity DCT stand-in.
module tb_dct_block_sequencer;

  localparam int W = 32;
  localparam int D = 8;
  localparam int L = 8;
  localparam int N = D * D;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [W*N-1:0] dct_in_matrix;
  logic [W*N-1:0] dct_out_matrix;
  logic           busy;
  logic           frame_err;
`ifdef DCT_SEQ_STATS_EN
  logic [15:0]    blk_count;
`endif

  dct_block_sequencer #(.DATA_WIDTH(W), .DATA_DEPTH(D), .DCT_LATENCY(L)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .dct_in_matrix  (dct_in_matrix),
    .dct_out_matrix (dct_out_matrix),
    .busy           (busy),
`ifdef DCT_SEQ_STATS_EN
    .blk_count      (blk_count),
`endif
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  // Identity DCT stand-in: L-1 register stages, so a capture earlier than L cycles sees stale data.
  logic [W*N-1:0] dpipe [L-1];
  always @(posedge clk) begin
    dpipe[0] <= dct_in_matrix;
    for (int s = 1; s < L - 1; s++) dpipe[s] <= dpipe[s-1];
  end
  assign dct_out_matrix = dpipe[L-2];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words collected for the current block, cycles since it filled, drain position.
  int           acc = 0;
  int           since = 0;
  int           oidx = 0;
  bit           m_ferr = 1'b0;
  int           m_blocks = 0;
  logic [W-1:0] blk [N];
  int           cyc = 0;
  int           first_hs = -1;
  int           first_ov = -1;
  int           total_out = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      acc = 0; since = 0; oidx = 0; m_ferr = 1'b0; m_blocks = 0;
    end else if (acc < N) begin
      if (in_valid) begin
        if (in_last !== (acc == N - 1)) m_ferr = 1'b1;
        blk[acc] = in_data;
        acc++;
        if (acc == N) begin
          since = 1;
          if (first_hs < 0) first_hs = cyc - 1;
        end
      end
    end else if (since <= L) begin
      since++;
    end else if (out_ready) begin
      if (oidx == N - 1) begin
        acc = 0; oidx = 0; since = 0; m_blocks++;
      end else begin
        oidx++;
      end
    end
  end

  always @(negedge clk) begin
    int  bad;
    bit  ev;
    if (reset) begin
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset frame_err", frame_err, 0);
    end else begin
      ev = (acc == N) && (since > L);
      if (out_valid && first_ov < 0) first_ov = cyc;
      check("in_ready", in_ready, acc < N);
      check("out_valid", out_valid, ev);
      check("busy", busy, acc == N);
      check("frame_err", frame_err, m_ferr);
      if (ev) begin
        check("out_data", out_data, blk[oidx]);
        check("out_last", out_last, oidx == N - 1);
      end else begin
        check("out_last idle", out_last, 0);
      end
      if (acc == N) begin
        bad = -1;
        for (int i = 0; i < N; i++)
          if (bad < 0 && dct_in_matrix[i*W +: W] !== blk[i]) bad = i;
        checks++;
        if (bad >= 0) begin
          failures++;
          $display("FAIL dct_in_matrix word %0d: got %0h expected %0h at t=%0t",
                   bad, dct_in_matrix[bad*W +: W], blk[bad], $time);
        end
      end
`ifdef DCT_SEQ_STATS_EN
      check("blk_count", blk_count, m_blocks & 16'hFFFF);
`endif
    end
  end

  // vmode: 0 always valid, 1 toggling, 2 random. pat: 0 ramp i<<16, 1 random words.
  task automatic send_block(input int pat, input int last_pos, input int vmode);
    int i = 0;
    int guard = 0;
    bit ph = 1'b1;
    bit hs;
    while (i < N && guard < 2000) begin
      in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? ph : 1'($urandom_range(0, 1));
      ph       = ~ph;
      in_data  = pat ? W'($urandom) : W'(i << 16);
      in_last  = (i == last_pos);
      hs       = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i < N) check("send timeout words", i, N);
  endtask

  task automatic recv_block(input int stall_idx, input int stall_len, input logic [W-1:0] stall_exp,
                            input bit rand_bp, input int abort_idx,
                            output logic [W-1:0] first_dat, output logic [W-1:0] last_dat);
    int k = 0;
    int guard = 0;
    int stalled = 0;
    bit hs;
    first_dat = 'x;
    last_dat  = 'x;
    while (k < N && guard < 4000) begin
      if (out_valid && k == abort_idx) begin
        out_ready = 1'b0;
        pulse_reset();
        return;
      end
      if (out_valid && k == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        if (stalled == stall_len) begin
          check("stall holds word", out_data, stall_exp);
          check("stall in_ready", in_ready, 0);
        end
      end else begin
        out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      hs = out_valid && out_ready;
      if (hs && k == 0) first_dat = out_data;
      if (hs && out_last) last_dat = out_data;
      @(posedge clk); #1;
      if (hs) begin k++; total_out++; end
      guard++;
    end
    out_ready = 1'b0;
    if (k < N) check("recv timeout words", k, N);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("pulse out_valid", out_valid, 0);
    check("pulse in_ready", in_ready, 1);
    check("pulse frame_err", frame_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] fd, ld;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("post-reset in_ready", in_ready, 1);
    check("post-reset out_valid", out_valid, 0);
    check("post-reset frame_err", frame_err, 0);
    @(posedge clk); #1;

    // Ramp block, full throughput.
    send_block(0, N - 1, 0);
    recv_block(-1, 0, '0, 1'b0, -1, fd, ld);
    check("first valid latency", first_ov - first_hs, 9);
    check("ramp first word", fd, 32'h0000_0000);
    check("ramp last word", ld, 32'h003F_0000);

    // Toggling valid, random data, random backpressure.
    send_block(1, N - 1, 1);
    recv_block(-1, 0, '0, 1'b1, -1, fd, ld);

    // Long stall at index 10.
    send_block(0, N - 1, 0);
    recv_block(10, 20, 32'h000A_0000, 1'b0, -1, fd, ld);
    check("stall block last word", ld, 32'h003F_0000);

    // Early in_last on word 40.
    send_block(1, 40, 2);
    check("frame_err after early last", frame_err, 1);
    recv_block(-1, 0, '0, 1'b1, -1, fd, ld);
    check("frame_err sticky", frame_err, 1);

    // Reset mid-drain, then three clean blocks.
    send_block(0, N - 1, 0);
    recv_block(-1, 0, '0, 1'b0, 30, fd, ld);
    for (int b = 0; b < 3; b++) begin
      send_block(1, N - 1, 2);
      recv_block(-1, 0, '0, 1'b1, -1, fd, ld);
    end
    check("frame_err clean blocks", frame_err, 0);
    check("total outputs", total_out, 478);
`ifdef DCT_SEQ_STATS_EN
    check("blk_count after three", blk_count, 3);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
